rv_data_bus_ctrl: RTL and testbench

Data-bus controller between the core's LSU data port and the memory-mapped slaves: data RAM, seven-digit hex device, GPIO. It accepts one transaction at a time, decodes the address, and issues a single-cycle request to exactly one slave. It then waits for that slave's `rvalid` and returns a registered response to the core. Unmapped addresses and unresponsive slaves return an error response, so the core never hangs.

---
 rtl/rv_data_bus_ctrl_if.sv | 38 +++
 rtl/rv_data_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rv_data_bus_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_data_bus_ctrl_if.sv
// Bundles the core-side LSU data port and the three-slave memory-mapped side of the data-bus controller.
interface rv_data_bus_ctrl_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NSLV = 3
);
  logic                   data_req_i;
  logic                   data_gnt_o;
  logic                   data_we_i;
  logic [XLEN/8-1:0]      data_be_i;
  logic [XLEN-1:0]        data_addr_i;
  logic [XLEN-1:0]        data_wdata_i;
  logic                   data_rvalid_o;
  logic                   data_err_o;
  logic [XLEN-1:0]        data_rdata_o;
  logic [NSLV-1:0]        slv_req_o;
  logic [NSLV-1:0]        slv_we_o;
  logic [XLEN/8-1:0]      slv_be_o;
  logic [XLEN-1:0]        slv_addr_o;
  logic [XLEN-1:0]        slv_wdata_o;
  logic [NSLV-1:0]        slv_rvalid_i;
  logic [NSLV*XLEN-1:0]   slv_rdata_i;

  // Controller side.
  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
    input  slv_rvalid_i, slv_rdata_i
  );

  // Core plus slaves environment side.
  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
    output slv_rvalid_i, slv_rdata_i
  );
endinterface

// File: rtl/rv_data_bus_ctrl.sv
// Data-bus controller: one transaction at a time, address decode to RAM / hex / GPIO,
// bounded wait for the selected slave's rvalid, registered response to the core.
package rv_pkg;
  localparam int unsigned      XLEN        = 32;
  localparam logic [XLEN-1:0]  ADDRESS_HEX = 32'h8000_0000;
endpackage

module rv_data_bus_ctrl
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [XLEN-1:0] RAM_SIZE  = 32'h0001_0000,
  parameter logic [XLEN-1:0] HEX_ADDR  = ADDRESS_HEX,
  parameter logic [XLEN-1:0] GPIO_BASE = 32'h8000_0100,
  parameter int unsigned     GPIO_SIZE = 16,
  parameter int unsigned     TIMEOUT   = 15
) (
  input logic               clk_i,
  input logic               arstn_i,
  rv_data_bus_ctrl_if.slave bus
);

  localparam int unsigned NSLV = 3;
  localparam int unsigned BEW  = XLEN / 8;
  localparam int unsigned TW   = 8;

  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] GPIO_SZ    = XLEN'(GPIO_SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [NSLV-1:0] slv_req_q, slv_req_d;
  logic [NSLV-1:0] slv_we_q, slv_we_d;
  logic [BEW-1:0]  slv_be_q, slv_be_d;
  logic [XLEN-1:0] slv_addr_q, slv_addr_d;
  logic [XLEN-1:0] slv_wdata_q, slv_wdata_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            accept;
  logic [NSLV-1:0] hit;
  logic [NSLV-1:0] hit_sel;
  logic            sel_rvalid;
  logic [XLEN-1:0] sel_rdata;

  assign accept         = bus.data_req_i && (state_q == S_IDLE);
  assign bus.data_gnt_o = accept;

  // Range checks use offsets so a window ending at the top of the address space cannot wrap.
  always_comb begin
    hit[0]  = (bus.data_addr_i >= RAM_BASE) && ((bus.data_addr_i - RAM_BASE) < RAM_SIZE);
    hit[1]  = (bus.data_addr_i == HEX_ADDR);
    hit[2]  = (bus.data_addr_i >= GPIO_BASE) && ((bus.data_addr_i - GPIO_BASE) < GPIO_SZ);
    hit_sel = '0;
    if (hit[0])      hit_sel = 3'b001;
    else if (hit[1]) hit_sel = 3'b010;
    else if (hit[2]) hit_sel = 3'b100;
  end

  // Only the selected slave's response is visible; others may hold rvalid high.
  always_comb begin
    sel_rdata  = '0;
    sel_rvalid = |(bus.slv_rvalid_i & sel_q);
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | bus.slv_rdata_i[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    timer_d     = timer_q;
    slv_req_d   = '0;
    slv_we_d    = '0;
    slv_be_d    = slv_be_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    rvalid_d    = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          slv_addr_d  = bus.data_addr_i;
          slv_be_d    = bus.data_be_i;
          slv_wdata_d = bus.data_wdata_i;
          we_d        = bus.data_we_i;
          if (|hit_sel) begin
            sel_d     = hit_sel;
            slv_req_d = hit_sel;
            slv_we_d  = hit_sel & {NSLV{bus.data_we_i}};
            state_d   = S_ISSUE;
          end else begin
            sel_d    = '0;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            state_d  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sel_rvalid) begin
          rdata_d  = we_q ? '0 : sel_rdata;
          err_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      we_q        <= 1'b0;
      timer_q     <= '0;
      slv_req_q   <= '0;
      slv_we_q    <= '0;
      slv_be_q    <= '0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      timer_q     <= timer_d;
      slv_req_q   <= slv_req_d;
      slv_we_q    <= slv_we_d;
      slv_be_q    <= slv_be_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.slv_req_o     = slv_req_q;
  assign bus.slv_we_o      = slv_we_q;
  assign bus.slv_be_o      = slv_be_q;
  assign bus.slv_addr_o    = slv_addr_q;
  assign bus.slv_wdata_o   = slv_wdata_q;
  assign bus.data_rvalid_o = rvalid_q;
  assign bus.data_err_o    = err_q;
  assign bus.data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_rv_data_bus_ctrl.sv
// Directed bench for rv_data_bus_ctrl with small RAM / hex / GPIO slave models.
module tb_rv_data_bus_ctrl;

  localparam logic [31:0] HEX  = 32'h8000_0000;
  localparam logic [31:0] GPIO = 32'h8000_0104;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rv_data_bus_ctrl_if bus ();

  rv_data_bus_ctrl dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Slave models
  logic [2:0]  ram_lat   = 3'd1;
  logic [2:0]  ram_cnt   = 3'd0;
  logic [31:0] ram_data  = 32'h0;
  logic [31:0] hex_reg   = 32'h0;
  logic        hex_flag  = 1'b0;
  logic        hex_stuck = 1'b0;
  logic        gpio_flag = 1'b0;
  logic        gpio_en   = 1'b0;
  logic        gpio_force = 1'b0;

  always @(posedge clk) begin
    if (bus.slv_req_o[0])      ram_cnt <= ram_lat;
    else if (ram_cnt != 3'd0)  ram_cnt <= ram_cnt - 3'd1;
    hex_flag  <= bus.slv_req_o[1];
    gpio_flag <= bus.slv_req_o[2];
    if (bus.slv_req_o[1] && bus.slv_we_o[1]) hex_reg <= bus.slv_wdata_o;
  end

  assign bus.slv_rvalid_i = {(gpio_en & gpio_flag) | gpio_force,
                             hex_flag | hex_stuck,
                             ram_cnt == 3'd1};
  assign bus.slv_rdata_i  = {32'h5A5A_5A5A, hex_reg, ram_data};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.data_req_i   = req;
    bus.data_we_i    = we;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = addr;
    bus.data_wdata_i = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.data_be_i = 4'h0;
    cyc(); cyc();
    chk("rst_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    chk("rst_err",    32'(bus.data_err_o),    32'd0);
    chk("rst_rdata",  bus.data_rdata_o,       32'd0);
    chk("rst_req",    32'(bus.slv_req_o),     32'd0);
    chk("rst_we",     32'(bus.slv_we_o),      32'd0);
    chk("rst_addr",   bus.slv_addr_o,         32'd0);
    bus.data_req_i = 1'b1; #1;
    chk("rst_gnt_follow", 32'(bus.data_gnt_o), 32'd1);
    bus.data_req_i = 1'b0; #1;
    chk("rst_gnt_low", 32'(bus.data_gnt_o), 32'd0);
    arstn = 1'b1;
    cyc();

    // Hex write, then read back
    drive(1'b1, 1'b1, HEX, 32'h1234_5678); #1;
    chk("hexw_gnt", 32'(bus.data_gnt_o), 32'd1);
    cyc(); bus.data_req_i = 1'b0;
    chk("hexw_req_t1",   32'(bus.slv_req_o), 32'b010);
    chk("hexw_we_t1",    32'(bus.slv_we_o),  32'b010);
    chk("hexw_wdata_t1", bus.slv_wdata_o,    32'h1234_5678);
    cyc();
    chk("hexw_req_t2", 32'(bus.slv_req_o), 32'd0);
    chk("hexw_we_t2",  32'(bus.slv_we_o),  32'd0);
    chk("hexw_rv_t2",  32'(bus.data_rvalid_o), 32'd0);
    cyc();
    chk("hexw_rv_t3",  32'(bus.data_rvalid_o), 32'd1);
    chk("hexw_err_t3", 32'(bus.data_err_o),    32'd0);
    cyc();
    chk("hexw_rv_t4",  32'(bus.data_rvalid_o), 32'd0);
    drive(1'b1, 1'b0, HEX, 32'h0);
    cyc(); bus.data_req_i = 1'b0;
    chk("hexr_we_t1", 32'(bus.slv_we_o), 32'd0);
    cyc(); cyc();
    chk("hexr_rv_t3",    32'(bus.data_rvalid_o), 32'd1);
    chk("hexr_rdata_t3", bus.data_rdata_o,       32'h1234_5678);
    cyc();

    // RAM read, request held high to see grant withheld while busy
    ram_lat = 3'd1; ram_data = 32'hCAFE_0001;
    drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    cyc();
    chk("ram_req_t1", 32'(bus.slv_req_o), 32'b001);
    chk("ram_gnt_t1", 32'(bus.data_gnt_o), 32'd0);
    chk("ram_addr_t1", bus.slv_addr_o, 32'h0000_0004);
    cyc();
    chk("ram_gnt_t2", 32'(bus.data_gnt_o), 32'd0);
    cyc();
    chk("ram_gnt_t3",   32'(bus.data_gnt_o),    32'd0);
    chk("ram_rv_t3",    32'(bus.data_rvalid_o), 32'd1);
    chk("ram_err_t3",   32'(bus.data_err_o),    32'd0);
    chk("ram_rdata_t3", bus.data_rdata_o,       32'hCAFE_0001);
    bus.data_req_i = 1'b0;
    cyc();

    // Unmapped read
    drive(1'b1, 1'b0, 32'h4000_0000, 32'h0);
    cyc();
    chk("unm_req_t1",   32'(bus.slv_req_o),     32'd0);
    chk("unm_rv_t1",    32'(bus.data_rvalid_o), 32'd1);
    chk("unm_err_t1",   32'(bus.data_err_o),    32'd1);
    chk("unm_rdata_t1", bus.data_rdata_o,       32'd0);
    chk("unm_gnt_t1",   32'(bus.data_gnt_o),    32'd0);
    bus.data_req_i = 1'b0;
    cyc();
    chk("unm_rv_t2", 32'(bus.data_rvalid_o), 32'd0);
    bus.data_req_i = 1'b1; #1;
    chk("unm_gnt_t2", 32'(bus.data_gnt_o), 32'd1);
    bus.data_req_i = 1'b0;
    cyc();

    // GPIO timeout, then RAM recovers
    gpio_en = 1'b0;
    drive(1'b1, 1'b0, GPIO, 32'h0);
    cyc(); bus.data_req_i = 1'b0;
    chk("gto_req_t1", 32'(bus.slv_req_o), 32'b100);
    repeat (15) cyc();
    chk("gto_rv_t16", 32'(bus.data_rvalid_o), 32'd0);
    cyc();
    chk("gto_rv_t17",    32'(bus.data_rvalid_o), 32'd1);
    chk("gto_err_t17",   32'(bus.data_err_o),    32'd1);
    chk("gto_rdata_t17", bus.data_rdata_o,       32'd0);
    cyc();
    ram_data = 32'hDEAD_BEEF;
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    cyc(); bus.data_req_i = 1'b0;
    cyc(); cyc();
    chk("gto_ram_rv",    32'(bus.data_rvalid_o), 32'd1);
    chk("gto_ram_err",   32'(bus.data_err_o),    32'd0);
    chk("gto_ram_rdata", bus.data_rdata_o,       32'hDEAD_BEEF);
    cyc();

    // Hex rvalid stuck high while RAM stalls
    hex_stuck = 1'b1; ram_lat = 3'd4; ram_data = 32'h0BAD_F00D;
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    cyc(); bus.data_req_i = 1'b0;
    chk("stk_req_t1", 32'(bus.slv_req_o), 32'b001);
    cyc(); cyc();
    chk("stk_rv_t3", 32'(bus.data_rvalid_o), 32'd0);
    cyc(); cyc();
    chk("stk_rv_t5", 32'(bus.data_rvalid_o), 32'd0);
    cyc();
    chk("stk_rv_t6",    32'(bus.data_rvalid_o), 32'd1);
    chk("stk_rdata_t6", bus.data_rdata_o,       32'h0BAD_F00D);
    hex_stuck = 1'b0; ram_lat = 3'd1;
    cyc();

    // Reset in the middle of a GPIO read
    drive(1'b1, 1'b0, GPIO, 32'h0);
    cyc(); bus.data_req_i = 1'b0;
    cyc();
    arstn = 1'b0; #1;
    chk("mrst_req",    32'(bus.slv_req_o),     32'd0);
    chk("mrst_addr",   bus.slv_addr_o,         32'd0);
    chk("mrst_rdata",  bus.data_rdata_o,       32'd0);
    chk("mrst_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    bus.data_req_i = 1'b1; #1;
    chk("mrst_gnt", 32'(bus.data_gnt_o), 32'd1);
    bus.data_req_i = 1'b0;
    cyc();
    arstn = 1'b1;
    gpio_force = 1'b1;
    cyc();
    chk("late_rv_a", 32'(bus.data_rvalid_o), 32'd0);
    cyc();
    chk("late_rv_b", 32'(bus.data_rvalid_o), 32'd0);
    gpio_force = 1'b0;
    ram_data = 32'h0000_00A5;
    drive(1'b1, 1'b0, 32'h0000_0020, 32'h0); #1;
    chk("post_rst_gnt", 32'(bus.data_gnt_o), 32'd1);
    cyc(); bus.data_req_i = 1'b0;
    cyc(); cyc();
    chk("post_rst_rv",    32'(bus.data_rvalid_o), 32'd1);
    chk("post_rst_rdata", bus.data_rdata_o,       32'h0000_00A5);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
